// File: rtl/ledpanel_pkg.sv
// Shared ledpanel definitions: panel geometry, idle enable code, RGB565 layout,
// row-writer FSM states and the ctrl_addr packing used by writer and panels.
package ledpanel_pkg;

  localparam int         PANEL_WIDTH  = 64;
  localparam int         PANEL_HEIGHT = 32;
  localparam logic [7:0] CTRL_IDLE_EN = 8'hFF;

  localparam int RGB_BLUE_W  = 5;
  localparam int RGB_GREEN_W = 6;
  localparam int RGB_RED_W   = 5;

  // blue occupies [15:11], green [10:5], red [4:0]
  typedef struct packed {
    logic [RGB_BLUE_W-1:0]  blue;
    logic [RGB_GREEN_W-1:0] green;
    logic [RGB_RED_W-1:0]   red;
  } rgb565_t;

  typedef enum logic [2:0] {
    HDR_PANEL,
    HDR_ROW,
    PIX_LO,
    PIX_HI,
    DROP
  } row_wr_state_t;

  function automatic logic [15:0] pack_ctrl_addr(input logic [15:0] row,
                                                 input logic [15:0] col,
                                                 input int          col_bits);
    return (row << col_bits) | col;
  endfunction

endpackage

// File: rtl/ledpanel_row_writer.sv
// Row-packet parser driving the shared ledpanel write bus (ctrl_en/ctrl_addr/ctrl_wdat).
// Latency: one cycle from pixel high-byte acceptance to the write on the bus.
// Backpressure: none, in_ready held high after reset. LEDPANEL_ROW_WRITER_STATS_EN adds row counters.
module ledpanel_row_writer
  import ledpanel_pkg::*;
#(
  parameter int         WIDTH   = PANEL_WIDTH,
  parameter int         HEIGHT  = PANEL_HEIGHT,
  parameter logic [7:0] IDLE_EN = CTRL_IDLE_EN
) (
  input  logic        display_clock,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  ctrl_en,
  output logic [15:0] ctrl_addr,
  output logic [15:0] ctrl_wdat,
  output logic        frame_done,
  output logic        pkt_err
`ifdef LEDPANEL_ROW_WRITER_STATS_EN
  ,
  output logic [15:0] rows_ok,
  output logic [15:0] rows_err
`endif
);

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);

  row_wr_state_t    state_q, state_d;
  logic [7:0]       panel_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic [7:0]       lo_q;

  logic    accept, col_last, hdr_bad;
  logic    wr_go, err_go, frame_go, row_done;
  rgb565_t px;

  assign accept   = in_valid && in_ready;
  assign col_last = (col_q == COL_W'(WIDTH - 1));
  assign hdr_bad  = (panel_q == IDLE_EN) || ({1'b0, in_data} >= 9'(HEIGHT));
  assign px       = {in_data, lo_q};

  always_ff @(posedge display_clock or posedge reset) begin
    if (reset) state_q <= HDR_PANEL;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        HDR_PANEL: if (!in_last) state_d = HDR_ROW;
        HDR_ROW: begin
          if (in_last)      state_d = HDR_PANEL;
          else if (hdr_bad) state_d = DROP;
          else              state_d = PIX_LO;
        end
        PIX_LO:  state_d = in_last ? HDR_PANEL : PIX_HI;
        PIX_HI: begin
          if (in_last)       state_d = HDR_PANEL;
          else if (col_last) state_d = DROP;
          else               state_d = PIX_LO;
        end
        DROP:    if (in_last) state_d = HDR_PANEL;
        default: state_d = HDR_PANEL;
      endcase
    end
  end

  always_comb begin
    wr_go    = 1'b0;
    err_go   = 1'b0;
    row_done = 1'b0;
    frame_go = 1'b0;
    if (accept) begin
      case (state_q)
        HDR_PANEL: err_go = in_last;
        HDR_ROW:   err_go = in_last || hdr_bad;
        PIX_LO:    err_go = in_last;
        PIX_HI: begin
          wr_go    = 1'b1;
          row_done = col_last;
          frame_go = col_last && (row_q == ROW_W'(HEIGHT - 1));
          err_go   = !col_last && in_last;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge display_clock or posedge reset) begin
    if (reset) begin
      panel_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      lo_q    <= '0;
    end else if (accept) begin
      if (state_q == HDR_PANEL) panel_q <= in_data;
      if (state_q == HDR_ROW) begin
        row_q <= in_data[ROW_W-1:0];
        col_q <= '0;
      end
      if (state_q == PIX_LO) lo_q <= in_data;
      if (wr_go) col_q <= col_q + 1'b1;
    end
  end

  // Address/data hold their last values between writes; only ctrl_en idles.
  always_ff @(posedge display_clock or posedge reset) begin
    if (reset) begin
      in_ready   <= 1'b0;
      ctrl_en    <= IDLE_EN;
      ctrl_addr  <= '0;
      ctrl_wdat  <= '0;
      frame_done <= 1'b0;
      pkt_err    <= 1'b0;
    end else begin
      in_ready   <= 1'b1;
      frame_done <= frame_go;
      pkt_err    <= err_go;
      if (wr_go) begin
        ctrl_en   <= panel_q;
        ctrl_addr <= pack_ctrl_addr(16'(row_q), 16'(col_q), COL_W);
        ctrl_wdat <= px;
      end else begin
        ctrl_en   <= IDLE_EN;
      end
    end
  end

`ifdef LEDPANEL_ROW_WRITER_STATS_EN
  always_ff @(posedge display_clock or posedge reset) begin
    if (reset) begin
      rows_ok  <= '0;
      rows_err <= '0;
    end else begin
      if (row_done) rows_ok  <= rows_ok + 16'd1;
      if (err_go)   rows_err <= rows_err + 16'd1;
    end
  end
`endif

endmodule

// File: doc/ledpanel_row_writer.md
Name: ledpanel_row_writer

Overview:
- Write-side front end for the panel video memories: consumes a byte stream of row packets (from the UDP/Ethernet receive path) and produces the ctrl_en / ctrl_addr / ctrl_wdat write bus shared by all ledpanel instances.
- One row packet carries a panel index, a row index and WIDTH RGB565 pixels.
- The block emits exactly one single-cycle write per pixel, addressed by the panel index.

Parameters:
- WIDTH, 64: pixels per row; power of two.
- HEIGHT, 32: rows per panel; power of two.
- IDLE_EN, 8'hFF: value driven on ctrl_en when no write is in progress; reserved, never a valid panel index.

Ports:
- display_clock  in  1  sole clock; same clock the panels sample the write bus on.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  byte valid.
- in_last  in  1  marks the final byte of a packet.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- ctrl_en  out  8  target panel index; IDLE_EN when idle.
- ctrl_addr  out  16  {zeros, row[log2 HEIGHT-1:0], col[log2 WIDTH-1:0]}.
- ctrl_wdat  out  16  RGB565 pixel; blue[15:11], green[10:5], red[4:0].
- frame_done  out  1  one-cycle pulse when row HEIGHT-1 of any panel completes.
- pkt_err  out  1  one-cycle pulse when a packet is rejected or truncated.

Behaviour:
- Reset values (asynchronous, applied immediately on assertion):
  - ctrl_en=IDLE_EN, ctrl_addr=0, ctrl_wdat=0.
  - in_ready=0, frame_done=0, pkt_err=0.
  - FSM in HDR_PANEL.
- in_ready rises on the first clock edge after reset deasserts and stays 1. The block never back-pressures, because at most one write occurs per two bytes.
- Packet format: byte0 = panel, byte1 = row, then WIDTH pixel pairs. Each pair is low byte first, then high byte.
- FSM states and transitions:
  - HDR_PANEL: accepts byte0.
    - in_last on byte0 -> pkt_err, stay.
    - Otherwise latch panel -> HDR_ROW.
  - HDR_ROW: accepts byte1.
    - If panel==IDLE_EN or row>=HEIGHT or in_last -> pkt_err, then DROP (or HDR_PANEL if in_last).
    - Otherwise latch row, clear col -> PIX_LO.
  - PIX_LO: latch the low byte.
    - in_last here -> pkt_err, HDR_PANEL; no write.
    - Otherwise -> PIX_HI.
  - PIX_HI: on acceptance of the high byte, register a write for the next cycle:
    - ctrl_en=panel, ctrl_addr={row,col}, ctrl_wdat={hi,lo}.
    - col increments, wrapping at WIDTH.
    - If col was WIDTH-1: go to HDR_PANEL when in_last, else to DROP. The row is complete either way; pulse frame_done the same cycle as the write when row==HEIGHT-1.
    - If col<WIDTH-1 and in_last: truncation -> pkt_err, HDR_PANEL. The current pixel is still written.
    - Otherwise -> PIX_LO.
  - DROP: discard bytes until in_last, then -> HDR_PANEL. Surplus bytes after a complete row are dropped silently; pkt_err is raised only if entry to DROP came from a header error.
- Write bus rules:
  - ctrl_en returns to IDLE_EN the cycle after every write.
  - ctrl_addr and ctrl_wdat hold their last values while idle.
  - Write latency: one cycle from high-byte acceptance to the ctrl_en assertion.
  - Back-to-back pixels are at least two cycles apart.
- Pixels already written from a truncated packet remain in panel memory; there is no rollback.
- in_valid low stalls the FSM in its current state. Gaps of any length are allowed.
- Reset mid-packet: the partial packet is discarded. The next accepted byte is treated as byte0.
- frame_done and pkt_err never assert in the same cycle.

Optional Feature:
- Macro: LEDPANEL_ROW_WRITER_STATS_EN.
- Defined:
  - Adds outputs rows_ok[15:0] and rows_err[15:0].
  - rows_ok increments on every completed row; rows_err increments on every pkt_err pulse.
  - Both counters wrap at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package ledpanel_pkg:
  - Constants: PANEL_WIDTH, PANEL_HEIGHT, CTRL_IDLE_EN, RGB565 field positions.
  - State enum typedef for this FSM.
  - ctrl_addr packing function, reused by ledpanel.
- No sub-module; the FSM, column counter and output register are one flat module.

Test Plan:
- Valid packet {8'h02, 8'h05, 64 pairs lo=i, hi=8'hA0} -> 64 writes with ctrl_en=2, ctrl_addr=0x0140+i, ctrl_wdat=0xA000|i; no pkt_err; ctrl_en=8'hFF between writes.
- Packet panel=0, row=31 complete -> frame_done pulses with the 64th write.
- Header panel=8'hFF, or row=32, followed by 130 bytes -> no writes, one pkt_err, FSM back in HDR_PANEL; the next valid packet writes correctly.
- Truncation: in_last on the high byte of pixel 9 -> 10 writes (cols 0-9), pkt_err, next byte parsed as panel.
- Random in_valid gaps (about 50% duty) on the valid-packet case -> an identical write sequence.
- Reset asserted after 20 pixels, then a fresh packet -> ctrl_en=8'hFF immediately; the new packet writes from col 0. With STATS_EN defined, rows_ok and rows_err are checked after each case.
